// File: rtl/fetch_sequencer.sv
// +----------------------------------------------------------------------+
// | Module      : fetch_sequencer                                        |
// | Description : Program-level controller for the PC/InstROM fetch      |
// |               unit. Launches a resident program on a host request,   |
// |               passes decode branches through, freezes on stall or    |
// |               halt instruction, and counts executed fetch cycles.    |
// | Options     : FETCH_SEQ_WATCHDOG_EN adds a RUN-cycle watchdog with   |
// |               parameter WDOG_LIMIT and output port timeout.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer #(
   parameter int          NUM_PROGS   = 4,
   parameter logic [7:0]  LAUNCH_BASE = 8'd0,
   parameter logic [8:0]  HALT_INSTR  = 9'h1FF,
   parameter int          CNT_W       = 16,
`ifdef FETCH_SEQ_WATCHDOG_EN
   parameter int          WDOG_LIMIT  = 1023,
`endif
   localparam int         SEL_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             req,
   input  logic [SEL_W-1:0] prog_sel,
   input  logic             stall,
   input  logic [8:0]       instr_in,
   input  logic             branch_taken,
   input  logic [7:0]       branch_target,
   output logic             start,
   output logic             Halt,
   output logic             Branch,
   output logic [7:0]       Target,
   output logic             busy,
   output logic             done,
`ifdef FETCH_SEQ_WATCHDOG_EN
   output logic             timeout,
`endif
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   state_t           next_state;
   logic [SEL_W-1:0] sel_q;
   logic [31:0]      sel_ext;
   logic             sel_valid;
   logic             accept;
   logic             count_en;
   logic             is_halt;
`ifdef FETCH_SEQ_WATCHDOG_EN
   logic [31:0]      wd_cnt;
   logic             wd_fire;
`endif

   // Out-of-range selections are compared in 32 bits and fall back to program 0
   assign sel_ext   = 32'(prog_sel);
   assign sel_valid = (sel_ext < 32'(NUM_PROGS));
   assign is_halt   = (instr_in == HALT_INSTR);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // State register
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and fetch-unit control decode; RUN controls follow inputs directly
   always_comb begin
      next_state = state;
      start      = 1'b0;
      Halt       = 1'b0;
      Branch     = 1'b0;
      Target     = 8'd0;
      accept     = 1'b0;
      count_en   = 1'b0;
`ifdef FETCH_SEQ_WATCHDOG_EN
      wd_fire    = 1'b0;
`endif
      case (state)
         IDLE: begin
            start = 1'b1;
            if (req) begin
               accept     = 1'b1;
               next_state = LAUNCH;
            end
         end
         LAUNCH: begin
            if (sel_q != '0) begin
               Branch = 1'b1;
               Target = LAUNCH_BASE + 8'(sel_q) - 8'd1;
            end
            next_state = RUN;
         end
         RUN: begin
            if (is_halt) begin
               Halt       = 1'b1;
               count_en   = 1'b1;
               next_state = DONE;
            end else if (stall) begin
               Halt = 1'b1;
            end else begin
               Branch   = branch_taken;
               Target   = branch_taken ? branch_target : 8'd0;
               count_en = 1'b1;
            end
`ifdef FETCH_SEQ_WATCHDOG_EN
            // A halt arriving on the limit cycle is a normal completion
            if (!is_halt && (wd_cnt == 32'(WDOG_LIMIT - 1))) begin
               wd_fire    = 1'b1;
               next_state = DONE;
            end
`endif
         end
         DONE: begin
            Halt = 1'b1;
            if (!req) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Program select latch and saturating fetch-cycle counter
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         sel_q       <= '0;
         cycle_count <= '0;
      end else begin
         if (accept) begin
            sel_q       <= sel_valid ? prog_sel : '0;
            cycle_count <= '0;
         end else if (count_en && (cycle_count != CNT_MAX)) begin
            cycle_count <= cycle_count + CNT_ONE;
         end
      end
   end

`ifdef FETCH_SEQ_WATCHDOG_EN
   // Consecutive RUN-cycle watchdog; timeout drops together with done
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (state == LAUNCH) begin
            wd_cnt <= '0;
         end else if (state == RUN) begin
            wd_cnt <= wd_cnt + 32'd1;
         end
         if (wd_fire) begin
            timeout <= 1'b1;
         end else if ((state == DONE) && !req) begin
            timeout <= 1'b0;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_sequencer                                     |
// | Description : Directed self-checking bench for fetch_sequencer.      |
// |               Watchdog scenarios build when FETCH_SEQ_WATCHDOG_EN    |
// |               is defined.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_sequencer;

   localparam logic [8:0] HALT = 9'h1FF;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        req = 1'b0;
   logic [1:0]  prog_sel = 2'd0;
   logic        stall = 1'b0;
   logic [8:0]  instr_in = 9'd0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = 8'd0;
   logic        start, Halt, Branch, busy, done;
   logic [7:0]  Target;
   logic [15:0] cycle_count;
`ifdef FETCH_SEQ_WATCHDOG_EN
   logic        timeout;
`endif
   wire  [4:0]  ctl = {start, Halt, Branch, busy, done};

   int checks = 0;
   int passes = 0;

   fetch_sequencer #(
      .NUM_PROGS   (4),
      .LAUNCH_BASE (8'h10),
      .HALT_INSTR  (HALT),
`ifdef FETCH_SEQ_WATCHDOG_EN
      .WDOG_LIMIT  (8),
`endif
      .CNT_W       (16)
   ) dut (
      .CLK           (CLK),
      .RST_n         (RST_n),
      .req           (req),
      .prog_sel      (prog_sel),
      .stall         (stall),
      .instr_in      (instr_in),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .start         (start),
      .Halt          (Halt),
      .Branch        (Branch),
      .Target        (Target),
      .busy          (busy),
      .done          (done),
`ifdef FETCH_SEQ_WATCHDOG_EN
      .timeout       (timeout),
`endif
      .cycle_count   (cycle_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL tb_time_limit: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   // Requests a program at a negedge and returns at the next negedge (DUT in LAUNCH)
   task automatic launch(input logic [1:0] sel);
      @(negedge CLK);
      req = 1'b1; prog_sel = sel; stall = 1'b0; instr_in = 9'd0;
      branch_taken = 1'b0; branch_target = 8'd0;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      #2;
      checks++; if (ctl !== 5'b10000) $display("FAIL reset_ctl: got %b required %b", ctl, 5'b10000); else passes++;
      checks++; if (Target !== 8'd0) $display("FAIL reset_target: got %h required %h", Target, 8'd0); else passes++;
      checks++; if (cycle_count !== 16'd0) $display("FAIL reset_count: got %0d required 0", cycle_count); else passes++;
`ifdef FETCH_SEQ_WATCHDOG_EN
      checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b required 0", timeout); else passes++;
`endif
      @(negedge CLK);
      RST_n = 1'b1;
   endtask

   task automatic test_idle;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK); #1;
         checks++; if ({start, busy} !== 2'b10) $display("FAIL idle_%0d: got start/busy %b required 10", i, {start, busy}); else passes++;
      end
   endtask

   task automatic test_launch;
      launch(2'd2); #1;
      checks++; if (ctl !== 5'b00110) $display("FAIL launch_ctl: got %b required %b", ctl, 5'b00110); else passes++;
      checks++; if (Target !== 8'h11) $display("FAIL launch_target: got %h required 11", Target); else passes++;
      prog_sel = 2'd3;
      @(negedge CLK); instr_in = 9'h005; #1;
      checks++; if (ctl !== 5'b00010) $display("FAIL launch_run_ctl: got %b required %b", ctl, 5'b00010); else passes++;
      instr_in = HALT; #1;
      checks++; if (ctl !== 5'b01010) $display("FAIL launch_halt_ctl: got %b required %b", ctl, 5'b01010); else passes++;
      @(negedge CLK); instr_in = 9'd0; #1;
      checks++; if (ctl !== 5'b01011) $display("FAIL launch_done_ctl: got %b required %b", ctl, 5'b01011); else passes++;
      req = 1'b0;
      @(negedge CLK); #1;
      checks++; if (ctl !== 5'b10000) $display("FAIL launch_idle_ctl: got %b required %b", ctl, 5'b10000); else passes++;
   endtask

   task automatic test_run_to_halt;
      launch(2'd0); #1;
      checks++; if (ctl !== 5'b00010) $display("FAIL sel0_launch_ctl: got %b required %b", ctl, 5'b00010); else passes++;
      checks++; if (Target !== 8'd0) $display("FAIL sel0_launch_target: got %h required 00", Target); else passes++;
      checks++; if (cycle_count !== 16'd0) $display("FAIL sel0_count_clear: got %0d required 0", cycle_count); else passes++;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK); instr_in = 9'(i + 1); #1;
         checks++; if (ctl !== 5'b00010) $display("FAIL run_ctl_%0d: got %b required %b", i, ctl, 5'b00010); else passes++;
         checks++; if (cycle_count !== 16'(i)) $display("FAIL run_count_%0d: got %0d required %0d", i, cycle_count, i); else passes++;
      end
      @(negedge CLK); instr_in = HALT; #1;
      checks++; if (ctl !== 5'b01010) $display("FAIL halt_cycle_ctl: got %b required %b", ctl, 5'b01010); else passes++;
      @(negedge CLK); instr_in = 9'd0; #1;
      checks++; if (ctl !== 5'b01011) $display("FAIL halt_done_ctl: got %b required %b", ctl, 5'b01011); else passes++;
      checks++; if (cycle_count !== 16'd6) $display("FAIL halt_count: got %0d required 6", cycle_count); else passes++;
`ifdef FETCH_SEQ_WATCHDOG_EN
      checks++; if (timeout !== 1'b0) $display("FAIL halt_timeout: got %b required 0", timeout); else passes++;
`endif
      @(negedge CLK); #1;
      checks++; if (ctl !== 5'b01011) $display("FAIL done_hold_ctl: got %b required %b", ctl, 5'b01011); else passes++;
      req = 1'b0;
      @(negedge CLK); #1;
      checks++; if (ctl !== 5'b10000) $display("FAIL release_ctl: got %b required %b", ctl, 5'b10000); else passes++;
      checks++; if (cycle_count !== 16'd6) $display("FAIL idle_count_hold: got %0d required 6", cycle_count); else passes++;
   endtask

   task automatic test_stall_branch;
      launch(2'd1); #1;
      checks++; if (Target !== 8'h10) $display("FAIL sel1_target: got %h required 10", Target); else passes++;
      @(negedge CLK); instr_in = 9'h010; #1;
      checks++; if (cycle_count !== 16'd0) $display("FAIL sb_count0: got %0d required 0", cycle_count); else passes++;
      @(negedge CLK); stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h55; #1;
      checks++; if (ctl !== 5'b01010) $display("FAIL stall_ctl: got %b required %b", ctl, 5'b01010); else passes++;
      checks++; if (Target !== 8'd0) $display("FAIL stall_target: got %h required 00", Target); else passes++;
      checks++; if (cycle_count !== 16'd1) $display("FAIL stall_count_pre: got %0d required 1", cycle_count); else passes++;
      @(negedge CLK); stall = 1'b0; branch_target = 8'h2A; #1;
      checks++; if (ctl !== 5'b00110) $display("FAIL branch_ctl: got %b required %b", ctl, 5'b00110); else passes++;
      checks++; if (Target !== 8'h2A) $display("FAIL branch_target: got %h required 2A", Target); else passes++;
      checks++; if (cycle_count !== 16'd1) $display("FAIL stall_count_frozen: got %0d required 1", cycle_count); else passes++;
      @(negedge CLK); instr_in = HALT; branch_target = 8'h77; #1;
      checks++; if (ctl !== 5'b01010) $display("FAIL halt_over_branch_ctl: got %b required %b", ctl, 5'b01010); else passes++;
      checks++; if (cycle_count !== 16'd2) $display("FAIL branch_count: got %0d required 2", cycle_count); else passes++;
      @(negedge CLK); instr_in = 9'd0; branch_taken = 1'b0; #1;
      checks++; if (ctl !== 5'b01011) $display("FAIL sb_done_ctl: got %b required %b", ctl, 5'b01011); else passes++;
      checks++; if (cycle_count !== 16'd3) $display("FAIL sb_done_count: got %0d required 3", cycle_count); else passes++;
      req = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset_midrun;
      launch(2'd3); #1;
      checks++; if (Target !== 8'h12) $display("FAIL sel3_target: got %h required 12", Target); else passes++;
      @(negedge CLK); req = 1'b0; prog_sel = 2'd1; instr_in = 9'h001; #1;
      checks++; if (ctl !== 5'b00010) $display("FAIL ignore_req0_ctl: got %b required %b", ctl, 5'b00010); else passes++;
      checks++; if (Target !== 8'd0) $display("FAIL ignore_sel_target: got %h required 00", Target); else passes++;
      @(negedge CLK); req = 1'b1; prog_sel = 2'd2; #1;
      checks++; if (ctl !== 5'b00010) $display("FAIL ignore_req1_ctl: got %b required %b", ctl, 5'b00010); else passes++;
      @(negedge CLK); req = 1'b0; branch_taken = 1'b1; branch_target = 8'h33; #1;
      checks++; if (ctl !== 5'b00110) $display("FAIL prereset_ctl: got %b required %b", ctl, 5'b00110); else passes++;
      #2; RST_n = 1'b0; #1;
      checks++; if (ctl !== 5'b10000) $display("FAIL midrun_reset_ctl: got %b required %b", ctl, 5'b10000); else passes++;
      checks++; if (Target !== 8'd0) $display("FAIL midrun_reset_target: got %h required 00", Target); else passes++;
      checks++; if (cycle_count !== 16'd0) $display("FAIL midrun_reset_count: got %0d required 0", cycle_count); else passes++;
      @(negedge CLK); RST_n = 1'b1; branch_taken = 1'b0; instr_in = 9'd0;
      @(negedge CLK); #1;
      checks++; if (ctl !== 5'b10000) $display("FAIL post_reset_ctl: got %b required %b", ctl, 5'b10000); else passes++;
   endtask

`ifdef FETCH_SEQ_WATCHDOG_EN
   task automatic test_watchdog;
      launch(2'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK); instr_in = 9'h003; stall = (i == 3); #1;
         checks++; if ({busy, done, timeout} !== 3'b100) $display("FAIL wd_run_%0d: got busy/done/timeout %b required 100", i, {busy, done, timeout}); else passes++;
      end
      @(negedge CLK); stall = 1'b0; instr_in = 9'd0; #1;
      checks++; if (ctl !== 5'b01011) $display("FAIL wd_done_ctl: got %b required %b", ctl, 5'b01011); else passes++;
      checks++; if (timeout !== 1'b1) $display("FAIL wd_timeout: got %b required 1", timeout); else passes++;
      checks++; if (cycle_count !== 16'd7) $display("FAIL wd_count: got %0d required 7", cycle_count); else passes++;
      req = 1'b0;
      @(negedge CLK); #1;
      checks++; if ({done, busy, timeout} !== 3'b000) $display("FAIL wd_release: got done/busy/timeout %b required 000", {done, busy, timeout}); else passes++;
      launch(2'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK); instr_in = (i == 7) ? HALT : 9'h004;
      end
      @(negedge CLK); instr_in = 9'd0; #1;
      checks++; if ({done, timeout} !== 2'b10) $display("FAIL wd_halt_at_limit: got done/timeout %b required 10", {done, timeout}); else passes++;
      checks++; if (cycle_count !== 16'd8) $display("FAIL wd_halt_count: got %0d required 8", cycle_count); else passes++;
      req = 1'b0;
      @(negedge CLK);
   endtask
`endif

   initial begin
      test_reset();
      test_idle();
      test_launch();
      test_run_to_halt();
      test_stall_branch();
      test_reset_midrun();
`ifdef FETCH_SEQ_WATCHDOG_EN
      test_watchdog();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-level controller for the fetch unit (PC/InstROM pair).
- Accepts a host run request and launches one of several resident programs by driving the fetch unit's start/Halt/Branch/Target controls.
- Passes decode-stage branches through while running, and freezes fetch on stall or on the halt instruction.
- Reports completion through a req/done handshake and counts executed fetch cycles.

Parameters:
- NUM_PROGS, 4, number of selectable programs (prog_sel width = clog2(NUM_PROGS), minimum 1).
- LAUNCH_BASE, 8'd0, branch-LUT index of program 1's entry; program k>0 enters via Target = LAUNCH_BASE + k - 1.
- HALT_INSTR, 9'h1FF, instruction encoding that terminates a program.
- CNT_W, 16, width of cycle_count.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- req  in  1  host run request; level, held until done observed.
- prog_sel  in  clog2(NUM_PROGS)  program to run; sampled on req acceptance.
- stall  in  1  datapath stall; freezes PC while high.
- instr_in  in  9  current instruction from fetch unit.
- branch_taken  in  1  decode/ALU branch decision for instr_in.
- branch_target  in  8  branch-LUT index for instr_in.
- start  out  1  fetch unit PC reset/hold.
- Halt  out  1  fetch unit PC freeze.
- Branch  out  1  fetch unit branch enable.
- Target  out  8  fetch unit branch LUT index.
- busy  out  1  program launched and not yet acknowledged.
- done  out  1  program finished.
- cycle_count  out  CNT_W  fetch cycles executed by the last or current program.

Behaviour:
- States: IDLE, LAUNCH, RUN, DONE.
- Reset (async, any state): state=IDLE, start=1, Halt=0, Branch=0, Target=0, busy=0, done=0, cycle_count=0.

IDLE:
- start=1, Halt=0, Branch=0.
- req=1 at a rising edge → latch prog_sel into sel_q; clear cycle_count; go to LAUNCH.
- busy rises with the LAUNCH entry.

LAUNCH (exactly 1 cycle):
- start=0, Halt=0.
- sel_q≠0 → Branch=1, Target=LAUNCH_BASE+sel_q-1 (8-bit wrap).
- sel_q=0 → Branch=0, Target=0, so the PC falls through from 0.
- Next state: RUN.

RUN (start=0):
- Branch, Halt and Target are combinational from inputs this cycle, so they take effect at the same edge.
- Priority: halt instruction > stall > branch.
  - instr_in==HALT_INSTR → Halt=1, Branch=0; next state DONE; cycle_count increments for this cycle.
  - else stall=1 → Halt=1, Branch=0, Target=0; cycle_count unchanged.
  - else Halt=0, Branch=branch_taken, Target = branch_taken ? branch_target : 0; cycle_count increments.
- cycle_count saturates at 2^CNT_W-1; no wrap.

DONE:
- start=0, Halt=1, Branch=0, done=1, busy=1, cycle_count held.
- req=0 at an edge → IDLE; done and busy clear together.
- While req stays high the block remains in DONE; there is no auto-restart.

General rules:
- req changes outside IDLE and DONE are ignored.
- prog_sel changes after acceptance are ignored.
- prog_sel ≥ NUM_PROGS is accepted and runs as sel_q=0.
- All state and output registers are updated on the rising CLK edge; RST_n is applied asynchronously.

Optional Feature:
Macro: FETCH_SEQ_WATCHDOG_EN
- Defined:
  - Adds parameter WDOG_LIMIT (default 1023) and output port timeout (1 bit, reset 0).
  - In RUN, a counter of consecutive RUN cycles (stall cycles included) is cleared on LAUNCH.
  - When it reaches WDOG_LIMIT without the halt instruction: go to DONE and set timeout=1.
  - timeout clears with done on return to IDLE.
  - Halt instruction and limit in the same cycle → normal completion, timeout=0.
- Undefined: no timeout port and no counter; RUN exits only on HALT_INSTR or reset.

Test Plan:
- Reset then idle: RST_n low mid-cycle → outputs at reset values immediately; after release with req=0 for 10 cycles → start=1, busy=0 throughout.
- Launch program 2, NUM_PROGS=4, LAUNCH_BASE=8'h10: req=1, prog_sel=2 → next cycle Branch=1, Target=8'h11, start=0; following cycle state RUN with Branch=0.
- Run to halt: sel=0, feed 5 non-halt instructions then 9'h1FF → Halt=1 on the halt cycle, done=1 next cycle, cycle_count=6; drop req → IDLE, done=0, busy=0 one cycle later.
- Stall and branch priority: in RUN, stall=1 with branch_taken=1 → Branch=0, Halt=1, count frozen. Then stall=0, branch_taken=1, target=8'h2A → Branch=1, Target=8'h2A. Then halt instruction with branch_taken=1 → Branch=0, Halt=1.
- Reset mid-run and req ignoring: assert RST_n=0 during RUN → immediate IDLE outputs. Toggle prog_sel and req during RUN → no effect on Target or state.
- Watchdog (macro defined, WDOG_LIMIT=8): no halt instruction for 8 RUN cycles → DONE with timeout=1, done=1. Release req → both clear.
